// File: rtl/psum_spad_accum.sv
// Partial-sum scratchpad for one PE: a two-stage read-modify-write accumulate pipeline
// feeding a small register file, drained in address order over a valid/ready stream.
module psum_spad_accum #(
   parameter int PROD_WIDTH = 16,
   parameter int PSUM_WIDTH = 20,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clear,
   input  logic                  prod_valid,
   output logic                  prod_ready,
   input  logic [PROD_WIDTH-1:0] prod_data,
   input  logic [ADDR_WIDTH-1:0] prod_addr,
   input  logic                  prod_first,
   input  logic                  drain_start,
   input  logic [ADDR_WIDTH:0]   num_psum,
   output logic                  psum_out_valid,
   input  logic                  psum_out_ready,
   output logic [PSUM_WIDTH-1:0] psum_out_data,
   output logic                  psum_out_last,
   output logic                  busy
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   ONE_W   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      FLUSH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state;
   logic [PSUM_WIDTH-1:0] entry [DEPTH];

   logic                  s1_valid;
   logic                  s1_first;
   logic [ADDR_WIDTH-1:0] s1_addr;
   logic [PSUM_WIDTH-1:0] s1_prod;

   logic                  s2_valid;
   logic                  s2_first;
   logic [ADDR_WIDTH-1:0] s2_addr;
   logic [PSUM_WIDTH-1:0] s2_prod;
   logic [PSUM_WIDTH-1:0] s2_operand;

   logic [ADDR_WIDTH-1:0] idx;
   logic [ADDR_WIDTH:0]   num_lat;

   logic                  accept;
   logic                  handshake;
   logic                  is_last;
   logic [PSUM_WIDTH-1:0] prod_ext;
   logic [PSUM_WIDTH-1:0] s1_operand;
   logic [PSUM_WIDTH-1:0] s2_result;
   logic [ADDR_WIDTH:0]   num_clamped;

   assign prod_ready     = (state == ACCUM) && !clear;
   assign accept         = prod_valid && prod_ready;
   assign psum_out_valid = (state == DRAIN) && !clear;
   assign handshake      = psum_out_valid && psum_out_ready;
   assign is_last        = (({1'b0, idx} + ONE_W) == num_lat);
   assign psum_out_last  = psum_out_valid && is_last;
   assign psum_out_data  = psum_out_valid ? entry[idx] : '0;
   assign busy           = (state != ACCUM) || s1_valid || s2_valid;

   assign prod_ext    = PSUM_WIDTH'($signed(prod_data));
   assign num_clamped = (num_psum > DEPTH_W) ? DEPTH_W : num_psum;

   // The entry S2 is about to write is still stale in the register file, so forward it.
   assign s1_operand = (s2_valid && (s2_addr == s1_addr)) ? s2_result : entry[s1_addr];
   assign s2_result  = (s2_first ? '0 : s2_operand) + s2_prod;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid   <= 1'b0;
         s1_first   <= 1'b0;
         s1_addr    <= '0;
         s1_prod    <= '0;
         s2_valid   <= 1'b0;
         s2_first   <= 1'b0;
         s2_addr    <= '0;
         s2_prod    <= '0;
         s2_operand <= '0;
      end else if (clear) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_first <= prod_first;
            s1_addr  <= prod_addr;
            s1_prod  <= prod_ext;
         end
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_first   <= s1_first;
            s2_addr    <= s1_addr;
            s2_prod    <= s1_prod;
            s2_operand <= s1_operand;
         end
      end
   end

   // Pipeline writes and drain zeroing never coincide: draining waits for an empty pipeline.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      end else begin
         if (s2_valid) entry[s2_addr] <= s2_result;
         if (handshake) entry[idx] <= '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ACCUM;
         idx     <= '0;
         num_lat <= '0;
      end else if (clear) begin
         state <= ACCUM;
         idx   <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (drain_start) begin
                  state   <= FLUSH;
                  idx     <= '0;
                  num_lat <= num_clamped;
               end
            end
            FLUSH: begin
               if (!s1_valid && !s2_valid) begin
                  state <= (num_lat == '0) ? ACCUM : DRAIN;
               end
            end
            DRAIN: begin
               if (handshake) begin
                  idx <= idx + ONE_A;
                  if (is_last) state <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_psum_spad_accum.sv
// Randomized and directed bench for psum_spad_accum against a behavioural scratchpad model.
module tb_psum_spad_accum;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        clear = 1'b0;
   logic        prod_valid = 1'b0;
   logic        prod_ready;
   logic [15:0] prod_data = '0;
   logic [1:0]  prod_addr = '0;
   logic        prod_first = 1'b0;
   logic        drain_start = 1'b0;
   logic [2:0]  num_psum = '0;
   logic        psum_out_valid;
   logic        psum_out_ready = 1'b0;
   logic [19:0] psum_out_data;
   logic        psum_out_last;
   logic        busy;

   int checks = 0;
   int passes = 0;

   logic [19:0] got_data[$];
   logic        got_last[$];

   // Model: entries as plain numbers, mode 0=accumulating 1=flushing 2=draining,
   // plus which of the last two edges accepted a product (still in flight).
   logic [19:0] m_mem [4] = '{default: '0};
   int          m_mode = 0;
   int          m_cnt = 0;
   int          m_idx = 0;
   logic        m_acc1 = 1'b0;
   logic        m_acc2 = 1'b0;
   logic        m_acc_now;
   logic        m_hs;
   logic [19:0] m_ext;

   psum_spad_accum dut (
      .clk(clk),
      .rstn(rstn),
      .clear(clear),
      .prod_valid(prod_valid),
      .prod_ready(prod_ready),
      .prod_data(prod_data),
      .prod_addr(prod_addr),
      .prod_first(prod_first),
      .drain_start(drain_start),
      .num_psum(num_psum),
      .psum_out_valid(psum_out_valid),
      .psum_out_ready(psum_out_ready),
      .psum_out_data(psum_out_data),
      .psum_out_last(psum_out_last),
      .busy(busy)
   );

   always #5 clk = ~clk;

   assign m_acc_now = prod_valid && (m_mode == 0) && !clear;
   assign m_hs      = (m_mode == 2) && !clear && psum_out_ready;
   assign m_ext     = {{4{prod_data[15]}}, prod_data};

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 4; i++) m_mem[i] <= '0;
         m_mode <= 0;
         m_cnt  <= 0;
         m_idx  <= 0;
         m_acc1 <= 1'b0;
         m_acc2 <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < 4; i++) m_mem[i] <= '0;
         m_mode <= 0;
         m_idx  <= 0;
         m_acc1 <= 1'b0;
         m_acc2 <= 1'b0;
      end else begin
         if (m_mode == 1) begin
            if (!m_acc1 && !m_acc2) m_mode <= (m_cnt == 0) ? 0 : 2;
         end else if (m_mode == 0 && drain_start) begin
            m_mode <= 1;
            m_cnt  <= (num_psum > 3'd4) ? 4 : int'(num_psum);
            m_idx  <= 0;
         end else if (m_hs) begin
            m_mem[m_idx] <= '0;
            m_idx <= m_idx + 1;
            if (m_idx + 1 == m_cnt) m_mode <= 0;
         end
         if (m_acc_now) begin
            m_mem[prod_addr] <= prod_first ? m_ext : m_mem[prod_addr] + m_ext;
         end
         m_acc2 <= m_acc1;
         m_acc1 <= m_acc_now;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
   endtask

   // Every cycle, outputs must match what the model says the block is doing right now.
   always @(negedge clk) begin
      checkOutput("prod_ready", prod_ready, (m_mode == 0) && !clear);
      checkOutput("psum_out_valid", psum_out_valid, (m_mode == 2) && !clear);
      checkOutput("psum_out_data", psum_out_data,
                  ((m_mode == 2) && !clear) ? m_mem[m_idx[1:0]] : 20'd0);
      checkOutput("psum_out_last", psum_out_last, (m_mode == 2) && !clear && (m_idx + 1 == m_cnt));
      checkOutput("busy", busy, (m_mode != 0) || m_acc1 || m_acc2);
      if (psum_out_valid && psum_out_ready) begin
         got_data.push_back(psum_out_data);
         got_last.push_back(psum_out_last);
      end
   end

   function automatic logic [19:0] gotData(input int i);
      if (i < got_data.size()) return got_data[i];
      return 'x;
   endfunction

   function automatic logic gotLast(input int i);
      if (i < got_last.size()) return got_last[i];
      return 1'bx;
   endfunction

   task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [1:0] a, input logic f,
                                input logic ds, input logic [2:0] n, input logic rdy, input logic clr);
      prod_valid     = v;
      prod_data      = d;
      prod_addr      = a;
      prod_first     = f;
      drain_start    = ds;
      num_psum       = n;
      psum_out_ready = rdy;
      clear          = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic prod(input logic [1:0] a, input int d, input logic f);
      applyStimulus(1'b1, 16'(d), a, f, 1'b0, 3'd0, 1'b0, 1'b0);
   endtask

   task automatic idle(input logic rdy);
      applyStimulus(1'b0, 16'd0, 2'd0, 1'b0, 1'b0, 3'd0, rdy, 1'b0);
   endtask

   task automatic runDrain(input int n, input logic [6:0] pat, input int plen);
      got_data.delete();
      got_last.delete();
      applyStimulus(1'b0, 16'd0, 2'd0, 1'b0, 1'b1, 3'(n), 1'b0, 1'b0);
      for (int c = 0; c < 60 && !(m_mode == 0 && !m_acc1 && !m_acc2); c++) idle(pat[c % plen]);
      checkOutput("drain_finished", prod_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_prod_ready", prod_ready, 1'b1);
      checkOutput("reset_valid", psum_out_valid, 1'b0);
      checkOutput("reset_data", psum_out_data, 20'd0);
      checkOutput("reset_last", psum_out_last, 1'b0);
      checkOutput("reset_busy", busy, 1'b0);
      rstn = 1'b1;
      idle(1'b0);

      // Basic accumulate with back-to-back accepts on one address
      prod(2'd0, 5, 1'b1);
      prod(2'd0, 3, 1'b0);
      prod(2'd0, -2, 1'b0);
      runDrain(1, 7'h7F, 1);
      checkOutput("basic_count", got_data.size(), 1);
      checkOutput("basic_value", gotData(0), 20'd6);
      checkOutput("basic_last", gotLast(0), 1'b1);
      runDrain(1, 7'h7F, 1);
      checkOutput("basic_zeroed", gotData(0), 20'd0);

      // Forwarding, then interleaving two addresses
      prod(2'd1, 10, 1'b1);
      prod(2'd1, 7, 1'b0);
      prod(2'd1, -20, 1'b0);
      prod(2'd2, 100, 1'b1);
      prod(2'd1, 5, 1'b0);
      prod(2'd2, -1, 1'b0);
      prod(2'd1, -5, 1'b0);
      runDrain(3, 7'h7F, 1);
      checkOutput("fwd_entry0", gotData(0), 20'd0);
      checkOutput("fwd_entry1", gotData(1), 20'hFFFFD);
      checkOutput("fwd_entry2", gotData(2), 20'd99);
      checkOutput("fwd_last", {gotLast(0), gotLast(1), gotLast(2)}, 3'b001);

      // Wrap in both directions
      prod(2'd0, 32767, 1'b1);
      repeat (15) prod(2'd0, 32767, 1'b0);
      prod(2'd0, 15, 1'b0);
      prod(2'd1, -32768, 1'b1);
      repeat (15) prod(2'd1, -32768, 1'b0);
      prod(2'd0, 1, 1'b0);
      prod(2'd1, -1, 1'b0);
      runDrain(2, 7'h7F, 1);
      checkOutput("wrap_pos", gotData(0), 20'h80000);
      checkOutput("wrap_neg", gotData(1), 20'h7FFFF);

      // Drain with backpressure pattern 1,0,0,1,1,0,1
      prod(2'd0, 1, 1'b1);
      prod(2'd1, 2, 1'b1);
      prod(2'd2, 3, 1'b1);
      prod(2'd3, 4, 1'b1);
      runDrain(4, 7'b1011001, 7);
      checkOutput("bp_count", got_data.size(), 4);
      for (int i = 0; i < 4; i++) checkOutput("bp_value", gotData(i), 20'(i + 1));
      checkOutput("bp_last", {gotLast(0), gotLast(1), gotLast(2), gotLast(3)}, 4'b0001);

      // Drain start with a product in the same cycle: valid three edges later
      applyStimulus(1'b1, 16'd9, 2'd0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
      checkOutput("dsprod_d0_valid", psum_out_valid, 1'b0);
      checkOutput("dsprod_d0_ready", prod_ready, 1'b0);
      idle(1'b1);
      checkOutput("dsprod_d1_valid", psum_out_valid, 1'b0);
      idle(1'b1);
      checkOutput("dsprod_d2_valid", psum_out_valid, 1'b0);
      idle(1'b1);
      checkOutput("dsprod_d3_valid", psum_out_valid, 1'b1);
      checkOutput("dsprod_d3_data", psum_out_data, 20'd9);
      checkOutput("dsprod_d3_last", psum_out_last, 1'b1);
      idle(1'b1);
      checkOutput("dsprod_ready_back", prod_ready, 1'b1);

      // Idle drain start: valid one edge later
      applyStimulus(1'b0, 16'd0, 2'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
      checkOutput("dsidle_d0_valid", psum_out_valid, 1'b0);
      idle(1'b0);
      checkOutput("dsidle_d1_valid", psum_out_valid, 1'b1);
      idle(1'b1);
      checkOutput("dsidle_ready_back", prod_ready, 1'b1);

      // num_psum of zero produces nothing
      got_data.delete();
      applyStimulus(1'b0, 16'd0, 2'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
      checkOutput("zero_flush_ready", prod_ready, 1'b0);
      idle(1'b1);
      checkOutput("zero_back_ready", prod_ready, 1'b1);
      checkOutput("zero_count", got_data.size(), 0);

      // num_psum above depth clamps to four entries
      for (int i = 0; i < 4; i++) prod(2'(i), 11 + i, 1'b1);
      runDrain(7, 7'h7F, 1);
      checkOutput("clamp_count", got_data.size(), 4);
      checkOutput("clamp_value3", gotData(3), 20'd14);
      checkOutput("clamp_last3", gotLast(3), 1'b1);

      // Clear after two of four outputs
      for (int i = 0; i < 4; i++) prod(2'(i), 5 + i, 1'b1);
      idle(1'b0);
      idle(1'b0);
      got_data.delete();
      applyStimulus(1'b0, 16'd0, 2'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      checkOutput("clr_pre_count", got_data.size(), 2);
      clear = 1'b1;
      #1;
      checkOutput("clr_valid_drop", psum_out_valid, 1'b0);
      @(posedge clk);
      #1;
      clear = 1'b0;
      psum_out_ready = 1'b0;
      #1;
      checkOutput("clr_ready_back", prod_ready, 1'b1);
      runDrain(4, 7'h7F, 1);
      for (int i = 0; i < 4; i++) checkOutput("clr_zeroed", gotData(i), 20'd0);

      // Reset after two of four outputs
      for (int i = 0; i < 4; i++) prod(2'(i), 21 + i, 1'b1);
      idle(1'b0);
      idle(1'b0);
      got_data.delete();
      applyStimulus(1'b0, 16'd0, 2'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      checkOutput("rst_pre_count", got_data.size(), 2);
      rstn = 1'b0;
      #1;
      checkOutput("rst_valid", psum_out_valid, 1'b0);
      checkOutput("rst_ready", prod_ready, 1'b1);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_data", psum_out_data, 20'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      psum_out_ready = 1'b0;
      runDrain(4, 7'h7F, 1);
      for (int i = 0; i < 4; i++) checkOutput("rst_zeroed", gotData(i), 20'd0);

      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 2'($urandom_range(0, 3)),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
                       3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
                       $urandom_range(0, 99) == 0);
      end
      idle(1'b1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/psum_spad_accum.md
# psum_spad_accum

Partial-sum scratchpad with a read-modify-write accumulate pipeline for one PE. It sits directly downstream of the psum address counter. Each MAC product is accumulated into the psum entry selected by the counter's 2-bit address. On request, the block drains the completed psums in address order over a valid/ready stream toward the next PE or the GLB.

## Interface
- PROD_WIDTH, 16, signed MAC product width
- PSUM_WIDTH, 20, signed psum entry width; must be ≥ PROD_WIDTH
- ADDR_WIDTH, 2, psum address width; DEPTH = 2^ADDR_WIDTH (4)

Ports:
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear; highest priority after reset
- prod_valid  in  1  product present
- prod_ready  out  1  product accepted when valid & ready
- prod_data  in  PROD_WIDTH  signed product
- prod_addr  in  ADDR_WIDTH  target entry (from address counter count)
- prod_first  in  1  first product of this psum: overwrite instead of accumulate
- drain_start  in  1  request to stream out entries
- num_psum  in  ADDR_WIDTH+1  entries to drain, sampled with drain_start
- psum_out_valid  out  1  output entry present
- psum_out_ready  in  1  downstream accept
- psum_out_data  out  PSUM_WIDTH  entry value
- psum_out_last  out  1  high with final drained entry
- busy  out  1  high in FLUSH or DRAIN, or while the pipeline holds a product

## Operation
- Storage: DEPTH × PSUM_WIDTH registers; every entry resets to 0.
- FSM states: ACCUM (reset state), FLUSH, DRAIN.
- prod_ready = (state == ACCUM) & !clear.
- Pipeline stage S1 (acceptance edge): registers addr, first, and sign-extended product; reads entry[addr] into an operand.
- Forwarding: if S2 is writing the same address in the cycle S1 reads it, S1 takes S2's result instead.
- Pipeline stage S2: result = (first ? 0 : operand) + product; writes entry[addr].
- Arithmetic is two's complement, modulo 2^PSUM_WIDTH: wrap, no saturation, no overflow flag.
- ACCUM→FLUSH on drain_start; the drain index is set to 0.
- num_psum is latched at drain_start and clamped: 0 means drain nothing, values above DEPTH become DEPTH.
- A product presented with drain_start in the same cycle is still accepted.
- drain_start is ignored outside ACCUM.
- FLUSH→DRAIN at the first edge where S1 and S2 are both empty. If latched num_psum is 0, FLUSH goes to ACCUM instead and no output is produced.
- In DRAIN:
  - psum_out_valid = 1.
  - psum_out_data = entry[idx], combinational read.
  - psum_out_last = (idx == num_psum − 1).
  - On each handshake, entry[idx] is zeroed and idx increments.
  - The handshake with last asserted returns the FSM to ACCUM.
- psum_out_data and psum_out_last hold steady while valid is high and ready is low.
- clear: zeroes all entries, invalidates S1/S2, forces ACCUM, and drops psum_out_valid in the same cycle.

## Timing
- Reset values: prod_ready 1, psum_out_valid 0, psum_out_data 0, psum_out_last 0, busy 0.
- Accept latency: a product accepted at edge E is visible in its entry after edge E+2. Accepts can be back-to-back at one per cycle, including to the same address.
- Drain start, nothing in flight at drain edge D: psum_out_valid rises after D+1.
- Drain start, product accepted at D: psum_out_valid rises after D+3.
- Drain throughput: one entry per cycle while psum_out_ready is held high.
- prod_ready falls combinationally in the cycle after drain_start is taken. It returns the cycle after the last output handshake.
- rstn asserted mid-accumulate or mid-drain: all state is lost immediately and outputs return to reset values. No partial output completes.
- clear together with drain_start: clear wins and the drain is not started.
- clear together with prod_valid: the product is not accepted (prod_ready = 0).

## Test plan
- Basic accumulate: addr0 (first=1) 5, then 3, then −2 on consecutive cycles, then drain num_psum=1 → single output 6 with last=1; entry0 then reads 0.
- Forwarding: addr1 first=1 10, then addr1 7, then addr1 −20, back-to-back → drained value −3. Interleave with addr2 products to confirm no cross-address corruption.
- Wrap: PSUM_WIDTH=20, entry0 holds 0x7FFFF, add 1 → 0x80000 (−524288). Add −1 to an entry holding 0x80000 → 0x7FFFF.
- Drain with backpressure: entries 1, 2, 3, 4, num_psum=4, ready toggled 1,0,0,1,1,0,1 → outputs 1, 2, 3, 4 in order, data stable while stalled, last only on 4, prod_ready 0 throughout.
- Drain start timing:
  - drain_start with a product in the same cycle → valid rises exactly 3 edges later, including the product.
  - Idle drain_start → valid 1 edge later.
  - num_psum=0 → no output; FSM back in ACCUM after FLUSH.
- clear/reset mid-drain: clear after 2 of 4 outputs → valid drops the same cycle, all entries 0, prod_ready 1 next cycle. Repeat with rstn low → same end state, asynchronously.
